// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and phase enumeration
//
// Purpose : default 640x480@60 timing (in pixels / lines), derived totals,
//           counter width and the four-phase state type used by both the
//           horizontal and vertical phase counters.
// Ports   : none (package).
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;

  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;

  // Counter origin is the start of sync, so phases run in this order.
  typedef enum logic [1:0] {
    PH_SYNC_S  = 2'd0,
    PH_BACK_S  = 2'd1,
    PH_ACT_S   = 2'd2,
    PH_FRONT_S = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_phase_counter.sv
// rtl/vga_phase_counter.sv - position counter with SYNC/BACK/ACTIVE/FRONT phase FSM
//
// Purpose : one axis of the VGA raster. Counts 0..TOTAL-1 while i_en is high
//           and tracks the phase in a small FSM that advances when the count
//           reaches the last value of the current phase.
// Ports   : i_clk      - clock
//           i_rst_n    - synchronous active-low reset (count=TOTAL-1, FRONT)
//           i_en       - advance enable
//           o_count    - current position
//           o_in_sync  - registered, high while in the SYNC phase
//           o_act_next - phase after this edge is ACTIVE (for registering
//                        combined decodes in step with the count)
//           o_wrap     - this enabled edge wraps the count to 0
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int P_SYNC   = DEF_H_SYNC,
  parameter int P_BACK   = DEF_H_BACK,
  parameter int P_ACTIVE = DEF_H_ACTIVE,
  parameter int P_FRONT  = DEF_H_FRONT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_in_sync,
  output logic             o_act_next,
  output logic             o_wrap
);

  localparam int TOTAL = P_SYNC + P_BACK + P_ACTIVE + P_FRONT;

  localparam logic [CNT_W-1:0] L_SYNC_END = CNT_W'(P_SYNC - 1);
  localparam logic [CNT_W-1:0] L_BACK_END = CNT_W'(P_SYNC + P_BACK - 1);
  localparam logic [CNT_W-1:0] L_ACT_END  = CNT_W'(P_SYNC + P_BACK + P_ACTIVE - 1);
  localparam logic [CNT_W-1:0] L_LAST     = CNT_W'(TOTAL - 1);

  phase_e           r_state;
  phase_e           w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_in_sync;
  logic             w_sync_next;

  // State register: count, phase and the sync decode all move together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= PH_FRONT_S;
      r_count   <= L_LAST;
      r_in_sync <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_in_sync <= w_sync_next;
    end
  end

  // Next-state: hold unless enabled. ">=" also catches any out-of-range
  // count and forces it back to 0 / SYNC on the next enabled edge.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    o_wrap       = 1'b0;
    if (i_en) begin
      if (r_count >= L_LAST) begin
        w_count_next = '0;
        w_state_next = PH_SYNC_S;
        o_wrap       = 1'b1;
      end else begin
        w_count_next = r_count + 1'b1;
        case (r_state)
          PH_SYNC_S: if (r_count == L_SYNC_END) w_state_next = PH_BACK_S;
          PH_BACK_S: if (r_count == L_BACK_END) w_state_next = PH_ACT_S;
          PH_ACT_S:  if (r_count == L_ACT_END)  w_state_next = PH_FRONT_S;
          default:   w_state_next = r_state;
        endcase
      end
    end
  end

  // Output decode of the next state, so registered flags line up with count.
  always_comb begin
    w_sync_next = (w_state_next == PH_SYNC_S);
    o_act_next  = (w_state_next == PH_ACT_S);
  end

  assign o_count   = r_count;
  assign o_in_sync = r_in_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (counters, syncs, video enable)
//
// Purpose : generates HCOUNT/VCOUNT with origin at start of sync, active-low
//           syncs, VIDEO_ON and single-cycle line/frame start pulses. All
//           decoded outputs are registered and change together with the counts.
// Macro   : VGA_TIMING_DIV2_EN - when defined, PIX_TICK is an internal /2
//           toggle (first high on the second CLK after reset release);
//           when undefined, PIX_TICK is constant 1.
// Ports   : CLK          - board clock
//           RST_N        - synchronous active-low reset
//           HCOUNT       - pixel position in line, 0..H total-1
//           VCOUNT       - line position in frame, 0..V total-1
//           HSYNC_N      - horizontal sync, active low
//           VSYNC_N      - vertical sync, active low
//           VIDEO_ON     - inside both active regions
//           PIX_TICK     - pixel advance enable
//           LINE_START   - pulse in the cycle HCOUNT becomes 0
//           FRAME_START  - pulse in the cycle HCOUNT and VCOUNT become 0
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT
) (
  input  logic             CLK,
  input  logic             RST_N,
  output logic [CNT_W-1:0] HCOUNT,
  output logic [CNT_W-1:0] VCOUNT,
  output logic             HSYNC_N,
  output logic             VSYNC_N,
  output logic             VIDEO_ON,
  output logic             PIX_TICK,
  output logic             LINE_START,
  output logic             FRAME_START
);

  logic w_tick;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_h_sync;
  logic w_v_sync;
  logic w_h_act_next;
  logic w_v_act_next;
  logic r_video_on;
  logic r_line_start;
  logic r_frame_start;

`ifdef VGA_TIMING_DIV2_EN
  logic r_div;

  // Reset clears the phase so the first tick lands on the second CLK.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_div <= 1'b0;
    end else begin
      r_div <= ~r_div;
    end
  end

  assign w_tick = r_div;
`else
  assign w_tick = 1'b1;
`endif

  vga_phase_counter #(
    .P_SYNC   (H_SYNC),
    .P_BACK   (H_BACK),
    .P_ACTIVE (H_ACTIVE),
    .P_FRONT  (H_FRONT)
  ) u_h_counter (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_en       (w_tick),
    .o_count    (HCOUNT),
    .o_in_sync  (w_h_sync),
    .o_act_next (w_h_act_next),
    .o_wrap     (w_h_wrap)
  );

  // Vertical axis advances once per line, on the horizontal wrap.
  vga_phase_counter #(
    .P_SYNC   (V_SYNC),
    .P_BACK   (V_BACK),
    .P_ACTIVE (V_ACTIVE),
    .P_FRONT  (V_FRONT)
  ) u_v_counter (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_en       (w_h_wrap),
    .o_count    (VCOUNT),
    .o_in_sync  (w_v_sync),
    .o_act_next (w_v_act_next),
    .o_wrap     (w_v_wrap)
  );

  // Wrap strobes already include the tick, so the pulses drop after one CLK.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_video_on    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_video_on    <= w_h_act_next & w_v_act_next;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  assign HSYNC_N     = ~w_h_sync;
  assign VSYNC_N     = ~w_v_sync;
  assign VIDEO_ON    = r_video_on;
  assign PIX_TICK    = w_tick;
  assign LINE_START  = r_line_start;
  assign FRAME_START = r_frame_start;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with ports named CLK and RST_N.
REQ-002 The block SHALL have parameter H_SYNC, default 96: hsync pulse width in pixels.
REQ-003 The block SHALL have parameter H_BACK, default 48: horizontal back porch in pixels.
REQ-004 The block SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-005 The block SHALL have parameter H_FRONT, default 16: horizontal front porch in pixels.
REQ-006 The block SHALL have parameters V_SYNC, V_BACK, V_ACTIVE and V_FRONT, defaults 2, 33, 480 and 10: the same four phases in lines.
REQ-007 The block SHALL have input CLK, 1 bit: 50 MHz board clock.
REQ-008 The block SHALL have input RST_N, 1 bit: synchronous reset, active low.
REQ-009 The block SHALL have output HCOUNT, 10 bits: horizontal pixel position 0..H_TOTAL-1, where H_TOTAL = 800; it feeds the downstream colour-band state machine.
REQ-010 The block SHALL have output VCOUNT, 10 bits: line position 0..V_TOTAL-1, where V_TOTAL = 525.
REQ-011 The block SHALL have outputs HSYNC_N and VSYNC_N, 1 bit each: active-low sync pulses.
REQ-012 The block SHALL have output VIDEO_ON, 1 bit: high while in both the horizontal and vertical active regions.
REQ-013 The block SHALL have outputs PIX_TICK, LINE_START and FRAME_START, 1 bit each: single-CLK pulses.

Function
REQ-014 Counter origin SHALL be the start of sync, giving phase order SYNC -> BACK -> ACTIVE -> FRONT (defaults: H 0-95, 96-143, 144-783, 784-799; V 0-1, 2-34, 35-514, 515-524).
REQ-015 PIX_TICK SHALL be the advance enable, and HCOUNT, VCOUNT and all decoded outputs SHALL change only in the CLK cycle in which PIX_TICK is high.
REQ-016 On a tick, HCOUNT SHALL increment, or wrap from H_TOTAL-1 to 0.
REQ-017 VCOUNT SHALL increment only on a tick where HCOUNT wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-018 A horizontal phase FSM SHALL have states H_SYNC_S, H_BACK_S, H_ACT_S and H_FRONT_S, advancing on the tick where HCOUNT equals the last value of the current phase; a vertical FSM SHALL do the same on line wraps.
REQ-019 HSYNC_N, VSYNC_N and VIDEO_ON SHALL be registered and coincide exactly with the HCOUNT/VCOUNT values they decode, with zero cycles of skew.
REQ-020 HSYNC_N SHALL be 0 exactly when the horizontal FSM is in H_SYNC_S, and VSYNC_N SHALL be 0 exactly when the vertical FSM is in its SYNC state.
REQ-021 VIDEO_ON SHALL be high exactly when both FSMs are in their ACTIVE state.
REQ-022 LINE_START SHALL pulse in the cycle in which HCOUNT becomes 0.
REQ-023 FRAME_START SHALL pulse in the cycle in which HCOUNT and VCOUNT both become 0; on that cycle LINE_START SHALL also pulse.
REQ-024 Counters SHALL never hold values of H_TOTAL/V_TOTAL or above, and any out-of-range value SHALL force a wrap to 0 on the next tick.

Reset
REQ-025 While RST_N = 0 at a CLK edge, outputs SHALL be HCOUNT = H_TOTAL-1, VCOUNT = V_TOTAL-1, both FSMs in FRONT, HSYNC_N = 1, VSYNC_N = 1, VIDEO_ON = 0, and all pulses 0.
REQ-026 These reset values SHALL also clear the divider phase.
REQ-027 The first tick after reset release SHALL produce HCOUNT = 0, VCOUNT = 0 and FRAME_START = 1.
REQ-028 Reset asserted mid-frame SHALL take effect at the next CLK edge, with no partial sync pulse extended.

Configuration
REQ-029 Macro VGA_TIMING_DIV2_EN SHALL select the tick source.
REQ-030 With VGA_TIMING_DIV2_EN defined, an internal toggle SHALL make PIX_TICK high every second CLK (25 MHz from 50 MHz), with the first high on the second CLK after reset release.
REQ-031 With VGA_TIMING_DIV2_EN undefined, PIX_TICK SHALL be constant 1 and the counters SHALL advance every CLK.

Structure
REQ-032 Package vga_timing_pkg SHALL hold the default timing constants, the derived H_TOTAL/V_TOTAL and the phase-state enumeration.
REQ-033 One sub-module, vga_phase_counter, SHALL implement the counter and phase FSM, instantiated twice: once for H with tick enable, and once for V with the H wrap as its enable.

Verification
REQ-034 Reset scenario: hold RST_N = 0 for 5 CLK then release -> HCOUNT = 799, VCOUNT = 524 and HSYNC_N = 1 during reset; first tick gives 0/0 with FRAME_START = 1.
REQ-035 Line timing scenario: run one line -> HSYNC_N low for exactly 96 ticks (HCOUNT 0-95), and VIDEO_ON high for HCOUNT 144-783 on VCOUNT = 35.
REQ-036 Frame timing scenario: run one full frame -> 800x525 = 420000 ticks between FRAME_START pulses, and VSYNC_N low on lines 0-1 only.
REQ-037 Wrap scenario: at HCOUNT = 799 and VCOUNT = 524, apply one tick -> both counters become 0 and LINE_START and FRAME_START assert together.
REQ-038 Mid-frame reset scenario: assert RST_N at HCOUNT = 50 inside hsync -> HSYNC_N = 1 on the next CLK and counts at 799/524.
REQ-039 Divider scenario: run with and without VGA_TIMING_DIV2_EN -> the CLK-cycle frame period is 840000 and 420000 respectively.
